// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, a carry flop and shift registers, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PRELAST = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             cprev_q, cprev_d;
   logic             ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_co;

   full_adder u_fa (
      .a  (ra_q[0]),
      .b  (rb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      // NOTE: every next-state value defaults to its register first so no path leaves it unassigned (no latches).
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      sreg_d  = sreg_q;
      carry_d = carry_q;
      count_d = count_q;
      s_d     = s_q;
      co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
      cprev_d = cprev_q;
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               carry_d = ci;
               count_d = '0;
               sreg_d  = '0;
`ifdef SERIAL_ADDER_OVF_EN
               cprev_d = 1'b0;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d  = {fa_s, sreg_q[WIDTH-1:1]};
            carry_d = fa_co;
            ra_d    = ra_q >> 1;
            rb_d    = rb_q >> 1;
            count_d = count_q + 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (count_q == PRELAST) cprev_d = fa_co;
`endif
            if (count_q == LAST) begin
               count_d = '0;
               s_d     = {fa_s, sreg_q[WIDTH-1:1]};
               co_d    = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = cprev_q ^ fa_co;
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         sreg_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         cprev_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         sreg_q  <= sreg_d;
         carry_q <= carry_d;
         count_q <= count_d;
         s_q     <= s_d;
         co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
         cprev_q <= cprev_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that consumes the team's one-bit full_adder cell (ports a, b, ci, s, co) and runs it LSB-first over WIDTH clock cycles. It sits directly downstream of the full adder: operand bits feed the cell, and its sum/carry outputs are captured each cycle. It replaces a WIDTH-wide ripple chain with one cell, a carry flip-flop and shift registers, under a start/done handshake.

## Interface
- WIDTH, 4: operand and sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- ci  in  1  carry-in; captured on accepted start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when s/co are updated.
- s  out  WIDTH  registered sum, held until the next completion.
- co  out  1  registered carry-out, held until the next completion.
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- State machine IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0. On start=1:
    - Load shift registers ra<=a, rb<=b, carry<=ci, count<=0, sreg<=0.
    - Go to SHIFT.
  - SHIFT: busy=1. Each cycle, feed ra[0], rb[0] and carry into full_adder.
    - Shift the cell's s into sreg from the MSB (sreg <= {fa_s, sreg[WIDTH-1:1]}).
    - Update carry<=fa_co.
    - Shift ra and rb right by one, and increment count.
    - When count==WIDTH-1 (the last bit), go to DONE.
    - In the same edge, load s<={fa_s, sreg[WIDTH-1:1]} and co<=fa_co.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start while busy=1 is ignored. a, b and ci may change freely after capture.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1). Operands are unsigned; the same bits are valid for two's complement.
- count width is clog2(WIDTH). count never exceeds WIDTH-1.
- rst=1 at any edge, including mid-SHIFT, aborts the operation:
  - State goes to IDLE.
  - busy, done, s, co and ovf go to 0; ra, rb, sreg, carry and count are cleared.
  - start in the same cycle as rst is ignored.

## Timing
- Reset values: busy=0, done=0, s=0, co=0, ovf=0.
- Start accepted at edge E0. SHIFT occupies the cycles after edges E0..E(WIDTH-1).
- s/co update at edge E(WIDTH), and done is high in the following cycle.
- Latency from the accepting edge to valid s/co is WIDTH edges; done is visible WIDTH cycles after start was sampled.
- Throughput is one addition per WIDTH+1 cycles; a start held high continuously restarts from DONE.
- busy rises the cycle after the accepting edge and falls in the DONE cycle.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the ovf port and a register cprev capturing the carry into the MSB position (carry value before the last SHIFT step).
  - At completion, ovf<=cprev^fa_co, and it is held like s/co.
- Not defined: the ovf port and cprev are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=4.
- After reset, a=0101, b=0011, ci=0, one start pulse -> done pulse 4 cycles later, s=1000, co=0; with OVF_EN, ovf=1.
- a=1111, b=0001, ci=0 -> s=0000, co=1; with OVF_EN, ovf=0.
- a=0000, b=0000, ci=1 -> s=0001, co=0. Then a=1111, b=1111, ci=1 -> s=1111, co=1.
- Start pulse, then change a/b and pulse start again 2 cycles later (while busy=1) -> first result only (0101+0011 gives s=1000), with a single done pulse.
- rst asserted 2 cycles into SHIFT -> next cycle busy=0, s=0000, co=0, no done pulse. A fresh start then completes correctly.
- start held high for 12 cycles with a=0110, b=0111 -> done every 5 cycles with s=1101, co=0 each time; with OVF_EN, ovf=1.
